// File: rtl/sram_sp_arbiter.sv
// sram_sp_arbiter: round-robin arbiter sharing one single-port SRAM wrapper
// among NUM_REQ requesters, with a latency-matched read tag pipeline that
// steers each read response back to its issuer.
//
// Optional feature macro: SRAM_ARB_WR_PRIO_EN
//   defined   -> pending writes win over reads (round-robin among writes)
//   undefined -> pure round-robin regardless of access type
module sram_sp_arbiter #(
  parameter  int unsigned NUM_REQ  = 2,
  parameter  int unsigned DATA_BIT = 64,
  parameter  int unsigned DEPTH    = 512,
  parameter  int unsigned RD_LAT   = 2,
  localparam int unsigned ADDR_BIT = $clog2(DEPTH)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ-1:0]           req_wen,
  input  logic [NUM_REQ*ADDR_BIT-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_BIT-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]           rsp_valid,
  output logic [DATA_BIT-1:0]          rsp_rdata,
  output logic [ADDR_BIT-1:0]          sram_addr,
  output logic                         sram_wen,
  output logic                         sram_ren,
  output logic [DATA_BIT-1:0]          sram_wdata,
  input  logic [DATA_BIT-1:0]          sram_rdata
);

  localparam int unsigned PTR_W = $clog2(NUM_REQ);
  // One extra bit so ptr+k can be wrapped modulo a non-power-of-two NUM_REQ.
  localparam int unsigned IDX_W = PTR_W + 1;

  // Round-robin pointer and read tag pipeline state.
  logic [PTR_W-1:0]             ptr_q, ptr_d;
  logic [RD_LAT-1:0]            tag_vld_q, tag_vld_d;
  logic [RD_LAT-1:0][PTR_W-1:0] tag_id_q, tag_id_d;

  // Arbitration result for the current cycle.
  logic [PTR_W-1:0] win_idx_c;
  logic             win_found_c;
  logic             grant_c;
  logic             grant_rd_c;

  // Scan ptr, ptr+1, ... modulo NUM_REQ and pick the first eligible requester.
  always_comb begin : pick_winner
    logic [IDX_W-1:0] sum;
    logic [PTR_W-1:0] idx;
    logic             any_found;
    logic [PTR_W-1:0] any_idx;
`ifdef SRAM_ARB_WR_PRIO_EN
    logic             wr_found;
    logic [PTR_W-1:0] wr_idx;
`endif
    sum       = '0;
    idx       = '0;
    any_found = 1'b0;
    any_idx   = '0;
`ifdef SRAM_ARB_WR_PRIO_EN
    wr_found  = 1'b0;
    wr_idx    = '0;
`endif
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      sum = IDX_W'(ptr_q) + IDX_W'(k);
      if (sum >= IDX_W'(NUM_REQ)) begin
        sum = sum - IDX_W'(NUM_REQ);
      end
      idx = sum[PTR_W-1:0];
      if (!any_found && req_valid[idx]) begin
        any_found = 1'b1;
        any_idx   = idx;
      end
`ifdef SRAM_ARB_WR_PRIO_EN
      if (!wr_found && req_valid[idx] && req_wen[idx]) begin
        wr_found = 1'b1;
        wr_idx   = idx;
      end
`endif
    end
    win_found_c = any_found;
    win_idx_c   = any_idx;
`ifdef SRAM_ARB_WR_PRIO_EN
    if (wr_found) begin
      win_idx_c = wr_idx;
    end
`endif
  end

  // No grants are issued while reset is asserted.
  assign grant_c    = win_found_c & ~rst;
  assign grant_rd_c = grant_c & ~req_wen[win_idx_c];

  // One-hot grant and SRAM command mux from the winning requester.
  always_comb begin : drive_grant
    req_ready  = '0;
    sram_addr  = '0;
    sram_wdata = '0;
    sram_wen   = 1'b0;
    sram_ren   = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_c && (win_idx_c == PTR_W'(i))) begin
        req_ready[i] = 1'b1;
        sram_addr    = req_addr[i*ADDR_BIT +: ADDR_BIT];
        sram_wdata   = req_wdata[i*DATA_BIT +: DATA_BIT];
        sram_wen     = req_wen[i];
        sram_ren     = ~req_wen[i];
      end
    end
  end

  // Next pointer and tag pipeline shift; stage 0 captures the read issuer.
  always_comb begin : next_state
    ptr_d     = ptr_q;
    tag_vld_d = '0;
    tag_id_d  = '0;
    if (grant_c) begin
      ptr_d = (win_idx_c == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx_c + PTR_W'(1);
    end
    tag_vld_d[0] = grant_rd_c;
    tag_id_d[0]  = grant_rd_c ? win_idx_c : '0;
    for (int unsigned s = 1; s < RD_LAT; s++) begin
      tag_vld_d[s] = tag_vld_q[s-1];
      tag_id_d[s]  = tag_id_q[s-1];
    end
  end

  // State registers with synchronous reset; reset drops in-flight reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q     <= '0;
      tag_vld_q <= '0;
      tag_id_q  <= '0;
    end else begin
      ptr_q     <= ptr_d;
      tag_vld_q <= tag_vld_d;
      tag_id_q  <= tag_id_d;
    end
  end

  // Decode the oldest tag into a one-hot response strobe.
  always_comb begin : drive_rsp
    rsp_valid = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      rsp_valid[i] = ~rst & tag_vld_q[RD_LAT-1] &
                     (tag_id_q[RD_LAT-1] == PTR_W'(i));
    end
  end

  assign rsp_rdata = sram_rdata;

endmodule

// File: tb/tb_sram_sp_arbiter.sv
// Testbench for sram_sp_arbiter (NUM_REQ=4) with a behavioural 2-cycle SRAM.
module tb_sram_sp_arbiter;

  localparam int unsigned NR = 4;
  localparam int unsigned DB = 64;
  localparam int unsigned AB = 9;

  logic                 clk;
  logic                 rst;
  logic [NR-1:0]        req_valid;
  logic [NR-1:0]        req_ready;
  logic [NR-1:0]        req_wen;
  logic [NR*AB-1:0]     req_addr;
  logic [NR*DB-1:0]     req_wdata;
  logic [NR-1:0]        rsp_valid;
  logic [DB-1:0]        rsp_rdata;
  logic [AB-1:0]        sram_addr;
  logic                 sram_wen;
  logic                 sram_ren;
  logic [DB-1:0]        sram_wdata;
  logic [DB-1:0]        sram_rdata;

  sram_sp_arbiter #(
    .NUM_REQ (NR),
    .DATA_BIT(DB),
    .DEPTH   (512),
    .RD_LAT  (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_wen   (req_wen),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .sram_addr (sram_addr),
    .sram_wen  (sram_wen),
    .sram_ren  (sram_ren),
    .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural single-port SRAM: write at the edge, read data two edges later.
  logic [DB-1:0] mem [512];
  logic [DB-1:0] rd_p0, rd_p1;
  initial begin
    for (int i = 0; i < 512; i++) mem[i] = '0;
    rd_p0 = '0;
    rd_p1 = '0;
  end
  always @(posedge clk) begin
    if (sram_wen) mem[sram_addr] <= sram_wdata;
    if (sram_ren) rd_p0 <= mem[sram_addr];
    rd_p1 <= rd_p0;
  end
  assign sram_rdata = rd_p1;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [NR-1:0] id;
    logic [DB-1:0] data;
    int            cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_total = 0;
  int   n_bad   = 0;
  logic mon_en  = 1'b0;

  localparam logic [DB-1:0] D1  = 64'h1111_2222_3333_0001;
  localparam logic [DB-1:0] D2  = 64'hA5A5_0000_FFFF_0002;
  localparam logic [DB-1:0] D3  = 64'h0123_4567_89AB_CDEF;
  localparam logic [DB-1:0] D4  = 64'hFEED_FACE_0000_0004;
  localparam logic [DB-1:0] DBF = 64'h0000_0000_DEAD_BEEF;

  task automatic chk(input string nm, input logic [DB-1:0] act, input logic [DB-1:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic w,
                         input logic [AB-1:0] a, input logic [DB-1:0] d);
    req_valid[i]          = v;
    req_wen[i]            = w;
    req_addr[i*AB +: AB]  = a;
    req_wdata[i*DB +: DB] = d;
  endtask

  task automatic clear_all();
    req_valid = '0;
    req_wen   = '0;
    req_addr  = '0;
    req_wdata = '0;
  endtask

  // Check grant and SRAM command for the current cycle, queue any read response.
  task automatic do_cycle(input logic [NR-1:0] er, input logic erd,
                          input logic [AB-1:0] ea, input logic [DB-1:0] ed,
                          input string nm);
    exp_t e;
    @(negedge clk);
    chk({nm, ".ready"}, DB'(req_ready), DB'(er));
    chk({nm, ".ren"}, DB'(sram_ren), DB'(erd));
    chk({nm, ".wen"}, DB'(sram_wen), DB'((er != '0) && !erd));
    if (er != '0) begin
      chk({nm, ".addr"}, DB'(sram_addr), DB'(ea));
      if (!erd) begin
        chk({nm, ".wdata"}, sram_wdata, ed);
      end else begin
        e.id   = er;
        e.data = ed;
        e.cyc  = cyc + 2;
        exp_q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Response monitor: pops the scoreboard whenever a response strobe appears.
  always @(negedge clk) begin
    if (mon_en) begin
      if (rsp_valid != '0) begin
        if (exp_q.size() == 0) begin
          n_total++;
          n_bad++;
          $display("FAIL rsp_unexpected: rsp_valid=%b data=%h cyc=%0d, none required",
                   rsp_valid, rsp_rdata, cyc);
        end else begin
          mon_e = exp_q.pop_front();
          chk("rsp_id", DB'(rsp_valid), DB'(mon_e.id));
          chk("rsp_data", rsp_rdata, mon_e.data);
          chk("rsp_cyc", DB'(cyc), DB'(mon_e.cyc));
        end
      end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
        mon_e = exp_q.pop_front();
        n_total++;
        n_bad++;
        $display("FAIL rsp_missing: rsp_valid=%b at cyc %0d, want %b", rsp_valid, cyc, mon_e.id);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  logic [AB-1:0] a_tab [NR];
  logic [DB-1:0] d_tab [NR];

  initial begin
    a_tab[0] = 9'd1; a_tab[1] = 9'd2; a_tab[2] = 9'd5; a_tab[3] = 9'd3;
    d_tab[0] = D1;   d_tab[1] = D2;   d_tab[2] = DBF;  d_tab[3] = D3;

    // Reset for 3 cycles, last two with all requesters asserting valid.
    rst = 1'b1;
    clear_all();
    do_cycle('0, 1'b0, '0, '0, "rst0");
    for (int i = 0; i < NR; i++) set_req(i, 1'b1, 1'b0, 9'(i), '0);
    do_cycle('0, 1'b0, '0, '0, "rst1");
    do_cycle('0, 1'b0, '0, '0, "rst2");
    rst = 1'b0;
    clear_all();
    mon_en = 1'b1;

    // Idle: no grants, no SRAM activity.
    for (int i = 0; i < 10; i++) do_cycle('0, 1'b0, '0, '0, "idle");

    // Single write then read of address 5 by requester 0.
    set_req(0, 1'b1, 1'b1, 9'd5, DBF);
    do_cycle(4'b0001, 1'b0, 9'd5, DBF, "wr5");
    set_req(0, 1'b1, 1'b0, 9'd5, '0);
    do_cycle(4'b0001, 1'b1, 9'd5, DBF, "rd5");
    clear_all();
    for (int i = 0; i < 3; i++) do_cycle('0, 1'b0, '0, '0, "drain1");

    // ptr=1: req1 writes addr 2, then req3 writes addr 1 (ptr wraps to 0).
    set_req(1, 1'b1, 1'b1, 9'd2, D2);
    do_cycle(4'b0010, 1'b0, 9'd2, D2, "wr2");
    clear_all();
    set_req(3, 1'b1, 1'b1, 9'd1, D1);
    do_cycle(4'b1000, 1'b0, 9'd1, D1, "wr1");
    clear_all();

    // Two continuous readers alternate with back-to-back responses.
    set_req(0, 1'b1, 1'b0, 9'd1, '0);
    set_req(1, 1'b1, 1'b0, 9'd2, '0);
    for (int k = 0; k < 4; k++) begin
      do_cycle(((k % 2) == 0) ? 4'b0001 : 4'b0010, 1'b1,
               ((k % 2) == 0) ? 9'd1 : 9'd2,
               ((k % 2) == 0) ? D1 : D2, "rr2");
    end
    clear_all();

    // ptr=2: req3 writes addr 3, pointer wraps back to 0.
    set_req(3, 1'b1, 1'b1, 9'd3, D3);
    do_cycle(4'b1000, 1'b0, 9'd3, D3, "wr3");
    clear_all();

    // All four requesters reading: grant order 0,1,2,3,0,1,2,3.
    for (int i = 0; i < NR; i++) set_req(i, 1'b1, 1'b0, a_tab[i], '0);
    for (int k = 0; k < 8; k++) begin
      do_cycle(4'(1 << (k % 4)), 1'b1, a_tab[k % 4], d_tab[k % 4], "rr4");
    end
    clear_all();
    for (int i = 0; i < 3; i++) do_cycle('0, 1'b0, '0, '0, "drain2");

    // Reset one cycle after a read grant: its response must never appear.
    set_req(1, 1'b1, 1'b0, 9'd2, '0);
    @(negedge clk);
    chk("midrst.ready", DB'(req_ready), DB'(4'b0010));
    chk("midrst.ren", DB'(sram_ren), DB'(1'b1));
    @(posedge clk);
    #1;
    clear_all();
    rst = 1'b1;
    do_cycle('0, 1'b0, '0, '0, "midrst.rst");
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("midrst.no_rsp", DB'(rsp_valid), '0);
      @(posedge clk);
      #1;
    end

    // ptr=0: req0 read and req1 write arrive together.
    set_req(0, 1'b1, 1'b0, 9'd1, '0);
    set_req(1, 1'b1, 1'b1, 9'd4, D4);
`ifdef SRAM_ARB_WR_PRIO_EN
    do_cycle(4'b0010, 1'b0, 9'd4, D4, "prio_wr_first");
    set_req(1, 1'b0, 1'b0, '0, '0);
    do_cycle(4'b0001, 1'b1, 9'd1, D1, "prio_rd_second");
    set_req(0, 1'b0, 1'b0, '0, '0);
`else
    do_cycle(4'b0001, 1'b1, 9'd1, D1, "rr_rd_first");
    set_req(0, 1'b0, 1'b0, '0, '0);
    do_cycle(4'b0010, 1'b0, 9'd4, D4, "rr_wr_second");
    set_req(1, 1'b0, 1'b0, '0, '0);
`endif
    // Read-after-write on the very next cycle returns the new data.
    set_req(2, 1'b1, 1'b0, 9'd4, '0);
    do_cycle(4'b0100, 1'b1, 9'd4, D4, "raw4");
    clear_all();
    for (int i = 0; i < 4; i++) do_cycle('0, 1'b0, '0, '0, "drain3");

    chk("scoreboard_empty", DB'(exp_q.size()), '0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/sram_sp_arbiter.md
# sram_sp_arbiter

Round-robin arbiter that shares one single-port SRAM wrapper instance (`sram_sp_sky130`) among `NUM_REQ` requesters. It issues at most one access per cycle to the SRAM and tracks in-flight reads through a latency-matched tag pipeline. Each read's data is returned to the requester that issued it. It sits between buffer/controller clients (e.g. weight loader, KV writer) and the SRAM wrapper.

## Interface
Parameters:
- `NUM_REQ`, 2: number of requesters, legal range 2..8.
- `DATA_BIT`, 64: SRAM word width; must match the wrapper.
- `DEPTH`, 512: SRAM words; `ADDR_BIT = $clog2(DEPTH)`.
- `RD_LAT`, 2: cycles from `sram_ren` to valid `sram_rdata`. The wrapper's macro read plus its output register gives 2.

Ports:
- `clk` in 1: single clock; all logic on posedge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in NUM_REQ: per-requester request valid.
- `req_ready` out NUM_REQ: per-requester grant, one-hot or zero.
- `req_wen` in NUM_REQ: 1 = write, 0 = read.
- `req_addr` in NUM_REQ*ADDR_BIT: flattened; requester i occupies `[i*ADDR_BIT +: ADDR_BIT]`.
- `req_wdata` in NUM_REQ*DATA_BIT: flattened write data, same packing.
- `rsp_valid` out NUM_REQ: one-hot pulse when read data for requester i is on `rsp_rdata`.
- `rsp_rdata` out DATA_BIT: shared read data.
- `sram_addr` out ADDR_BIT, `sram_wen` out 1, `sram_ren` out 1, `sram_wdata` out DATA_BIT: drive the wrapper.
- `sram_rdata` in DATA_BIT: wrapper read data.

## Operation
- Transfer on requester i occurs when `req_valid[i] & req_ready[i]`. Requesters hold valid, wen, addr and wdata stable until transferred.
- Grant logic is combinational on the current `req_valid` and the round-robin pointer `ptr`, width `$clog2(NUM_REQ)`.
  - Winner is the first valid index scanning `ptr, ptr+1, …` modulo NUM_REQ.
- On grant to i: `ptr <= (i+1) mod NUM_REQ`. With no valid request, `ptr` is unchanged.
- `sram_*` outputs are combinational from the winner:
  - `sram_wen = req_wen[i]`, `sram_ren = ~req_wen[i]`; addr and wdata are muxed from requester i.
  - With no winner: `sram_wen = sram_ren = 0`, addr and wdata = 0.
- Read tag pipeline: `RD_LAT` stages, each holding {valid, id}.
  - Stage 0 loads {1, i} on a read grant, otherwise {0, x}.
  - The last stage drives `rsp_valid = valid ? (1 << id) : 0`. `rsp_rdata = sram_rdata` unconditionally.
- Writes produce no response.
- Throughput: one access per cycle, back-to-back reads fully pipelined, no bubbles. There is no backpressure on responses; requesters must accept `rsp_valid` pulses.

## Timing
- Reset, active on the clock edge while `rst=1`:
  - `ptr = 0`, all tag stages invalid.
  - `req_ready = 0` while `rst` is high.
  - `rsp_valid = 0`, `rsp_rdata` follows `sram_rdata` (don't-care).
  - `sram_wen = sram_ren = 0`.
- Read granted in cycle T gives `rsp_valid[i] = 1` in cycle T+RD_LAT, with data valid in that same cycle.
- Write granted in cycle T commits to the SRAM at the T edge. A read of the same address granted in T+1 or later returns the new data.
- Simultaneous requests: exactly one grant per cycle. Losers keep `req_ready = 0` and retry the next cycle.
- Fairness: a continuously valid requester is granted within NUM_REQ cycles.
- Reset mid-operation: in-flight tags are cleared, so no `rsp_valid` is generated for reads issued before reset.
- `ptr` wrap: after granting requester NUM_REQ-1, `ptr` becomes 0.

## Configuration
- `SRAM_ARB_WR_PRIO_EN`:
  - Defined: if any valid requester has `req_wen = 1`, the winner is the first write requester in round-robin order from `ptr`. Reads are granted only when no write is pending. `ptr` updates as above.
  - Undefined: pure round-robin regardless of access type.

## Test plan
- Reset and idle: hold `rst` 3 cycles, then all `req_valid = 0` → `req_ready = 0`, `rsp_valid = 0`, `sram_wen = sram_ren = 0` for 10 cycles.
- Single write/read: req0 writes 0xDEADBEEF to addr 5 in cycle 10, reads addr 5 in cycle 11 → `rsp_valid = 2'b01` in cycle 13 with `rsp_rdata = 0xDEADBEEF`.
- Round-robin contention: NUM_REQ=2, both continuously reading addrs 1 and 2 → grants alternate 0,1,0,1. Responses alternate `rsp_valid` 01,10 with data from addrs 1 and 2, one per cycle, no bubbles.
- Pointer wrap, NUM_REQ=4: all four valid for 8 cycles → grant order 0,1,2,3,0,1,2,3.
- Reset mid-flight: req1 reads in cycle T, `rst` high in T+1 → no `rsp_valid` in T+2 or later.
- `SRAM_ARB_WR_PRIO_EN` defined: req0 reads and req1 writes in the same cycle with `ptr = 0` → req1 granted first and req0 the next cycle. With the macro undefined → req0 granted first.
